// File: rtl/prm_edge_mask_eval.sv
// Programmable edge-mask evaluator: a runtime-loadable table of product terms
// (care/value/enable) is scanned P terms per cycle against each sample of a
// roadmap edge. The edge reports a collision if any sample hits any enabled
// term. Once an edge has hit, its remaining samples are drained without scanning.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a sample; config writes allowed if no edge open
// SCAN   | comparing the latched sample, one term group per cycle
// DRAIN  | edge already hit; consume remaining samples until last
// OUT    | result held on m_* until m_ready
module prm_edge_mask_eval #(
    parameter  int IN_W      = 15,
    parameter  int NUM_TERMS = 128,
    parameter  int P         = 4,
    parameter  int ID_W      = 16,
    parameter  int CNT_W     = 8,
    localparam int AW        = $clog2(NUM_TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cfg_we,
    input  logic [AW-1:0]    i_cfg_addr,
    input  logic [IN_W-1:0]  i_cfg_care,
    input  logic [IN_W-1:0]  i_cfg_val,
    input  logic             i_cfg_en,
    output logic             o_cfg_ready,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [IN_W-1:0]  i_s_data,
    input  logic             i_s_last,
    input  logic [ID_W-1:0]  i_s_edge_id,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic             o_m_mask,
    output logic [ID_W-1:0]  o_m_edge_id,
    output logic [AW-1:0]    o_m_hit_term,
    output logic [CNT_W-1:0] o_m_samples,
    output logic             o_busy
);

    localparam int G  = NUM_TERMS / P;
    localparam int GW = $clog2(G);
    localparam int PW = $clog2(P);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_OUT} state_t;

    state_t              r_state;
    state_t              w_next;

    logic [IN_W-1:0]     r_care [NUM_TERMS];
    logic [IN_W-1:0]     r_val  [NUM_TERMS];
    logic [NUM_TERMS-1:0] r_en;

    logic [IN_W-1:0]     r_sample;
    logic                r_last;
    logic [GW-1:0]       r_grp;
    logic                r_open;
    logic                r_hit;
    logic [AW-1:0]       r_hit_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [ID_W-1:0]     r_edge_id;

    logic [AW-1:0]       w_term_idx [P];
    logic [P-1:0]        w_term_hit;
    logic                w_grp_hit;
    logic [AW-1:0]       w_first;
    logic                w_s_fire;
    logic                w_m_fire;
    logic                w_cfg_fire;

    assign w_s_fire   = i_s_valid && o_s_ready;
    assign w_m_fire   = o_m_valid && i_m_ready;
    assign w_cfg_fire = i_cfg_we && o_cfg_ready;

    // Term index within the current group is simply {group, lane}.
    for (genvar j = 0; j < P; j++) begin : g_cmp
        assign w_term_idx[j] = {r_grp, PW'(j)};
        assign w_term_hit[j] = r_en[w_term_idx[j]] &&
            (((r_sample ^ r_val[w_term_idx[j]]) & r_care[w_term_idx[j]]) == '0);
    end

    assign w_grp_hit = |w_term_hit;

    // Lowest-index matching lane wins; iterate downward so the last write is the lowest.
    always_comb begin
        w_first = '0;
        for (int j = P - 1; j >= 0; j--) begin
            if (w_term_hit[j]) begin
                w_first = w_term_idx[j];
            end
        end
    end

    // Term care/value storage; contents are only meaningful where the enable bit is set.
    always_ff @(posedge clk) begin
        if (w_cfg_fire) begin
            r_care[i_cfg_addr] <= i_cfg_care;
            r_val[i_cfg_addr]  <= i_cfg_val;
        end
    end

    // Term enables; reset empties the table so nothing matches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en <= '0;
        end else if (w_cfg_fire) begin
            r_en[i_cfg_addr] <= i_cfg_en;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        w_next      = r_state;
        o_s_ready   = 1'b0;
        o_cfg_ready = 1'b0;
        o_m_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_s_ready   = 1'b1;
                o_cfg_ready = !r_open;
                if (i_s_valid) begin
                    w_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_grp_hit) begin
                    w_next = r_last ? ST_OUT : ST_DRAIN;
                end else if (r_grp == GW'(G - 1)) begin
                    w_next = r_last ? ST_OUT : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                o_s_ready = 1'b1;
                if (i_s_valid && i_s_last) begin
                    w_next = ST_OUT;
                end
            end
            ST_OUT: begin
                o_m_valid = 1'b1;
                if (i_m_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Edge datapath: sample latch, group counter, first-hit capture, sample count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample  <= '0;
            r_last    <= 1'b0;
            r_grp     <= '0;
            r_open    <= 1'b0;
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
            r_cnt     <= '0;
            r_edge_id <= '0;
        end else begin
            if (w_s_fire) begin
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (r_state == ST_IDLE) begin
                    r_sample <= i_s_data;
                    r_last   <= i_s_last;
                    r_grp    <= '0;
                    r_open   <= 1'b1;
                    if (!r_open) begin
                        r_edge_id <= i_s_edge_id;
                    end
                end
            end
            if (r_state == ST_SCAN) begin
                r_grp <= r_grp + GW'(1);
                if (w_grp_hit) begin
                    r_hit     <= 1'b1;
                    r_hit_idx <= w_first;
                end
            end
            if (w_m_fire) begin
                r_hit     <= 1'b0;
                r_hit_idx <= '0;
                r_cnt     <= '0;
                r_open    <= 1'b0;
            end
        end
    end

    assign o_m_mask     = r_hit;
    assign o_m_hit_term = r_hit_idx;
    assign o_m_samples  = r_cnt;
    assign o_m_edge_id  = r_edge_id;
    assign o_busy       = r_open || (r_state == ST_OUT);

endmodule
